// File: rtl/seg7_readback.sv
// Reads back the six HEX display patterns, requires each to hold steady across a
// dwell interval, and decodes them into hex nibbles with valid/blank flags.
module seg7_readback #(
  parameter int unsigned DWELL          = 4,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        MODE,
  input  logic [2:0]  ADDR,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  input  logic [6:0]  HEX4,
  input  logic [6:0]  HEX5,
  output logic        BUSY,
  output logic        DONE,
  output logic [23:0] DIGITS,
  output logic [5:0]  VALID,
  output logic [5:0]  BLANK,
  output logic        ERR
);

  // state   | meaning
  // IDLE    | waiting for START; latches MODE/ADDR
  // SAMPLE  | capture first sample s0 of the current display
  // WAIT    | dwell down-counter running
  // COMPARE | compare current pattern against s0, decode or retry
  // NEXT    | advance to the next display or finish
  // FINISH  | one-cycle DONE pulse
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_NEXT    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY - 1);
  localparam logic [2:0]       LAST_ADDR = 3'd5;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [23:0]       digits_q, digits_d;
  logic [5:0]        valid_q, valid_d;
  logic [5:0]        blank_q, blank_d;
  logic              err_q, err_d;
  logic              mode_q, mode_d;
  logic [2:0]        cur_addr_q, cur_addr_d;
  logic [6:0]        s0_q, s0_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;

  logic [6:0] raw_pat;
  logic [6:0] s1;
  logic [3:0] dec_nib;
  logic       dec_valid;
  logic       dec_blank;

  always_comb begin
    raw_pat = 7'h00;
    case (cur_addr_q)
      3'd0:    raw_pat = HEX0;
      3'd1:    raw_pat = HEX1;
      3'd2:    raw_pat = HEX2;
      3'd3:    raw_pat = HEX3;
      3'd4:    raw_pat = HEX4;
      3'd5:    raw_pat = HEX5;
      default: raw_pat = 7'h00;
    endcase
  end

  // Normalise to active-high so the decode table is polarity independent.
  assign s1 = SEG_ACTIVE_LOW ? ~raw_pat : raw_pat;

  always_comb begin
    dec_nib   = 4'h0;
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    case (s1)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      7'h00: begin
        dec_valid = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    digits_d   = digits_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    err_d      = err_q;
    mode_d     = mode_q;
    cur_addr_d = cur_addr_q;
    s0_d       = s0_q;
    wait_cnt_d = wait_cnt_q;
    retry_d    = retry_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (START) begin
          mode_d = MODE;
          busy_d = 1'b1;
          if (MODE) begin
            valid_d    = 6'b0;
            blank_d    = 6'b0;
            err_d      = 1'b0;
            cur_addr_d = 3'd0;
            state_d    = S_SAMPLE;
          end else if (ADDR <= LAST_ADDR) begin
            valid_d[ADDR] = 1'b0;
            blank_d[ADDR] = 1'b0;
            err_d         = 1'b0;
            cur_addr_d    = ADDR;
            state_d       = S_SAMPLE;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end

      S_SAMPLE: begin
        s0_d       = s1;
        retry_d    = '0;
        wait_cnt_d = WAIT_LOAD;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end

      S_COMPARE: begin
        if (s1 == s0_q) begin
          digits_d[{cur_addr_q, 2'b00} +: 4] = dec_nib;
          valid_d[cur_addr_q]                = dec_valid;
          blank_d[cur_addr_q]                = dec_blank;
          state_d                            = S_NEXT;
        end else if (retry_q == RTY_LAST) begin
          digits_d[{cur_addr_q, 2'b00} +: 4] = 4'h0;
          valid_d[cur_addr_q]                = 1'b0;
          blank_d[cur_addr_q]                = 1'b0;
          err_d                              = 1'b1;
          state_d                            = S_NEXT;
        end else begin
          // Re-arm the dwell using the newer pattern as the reference.
          retry_d    = retry_q + RTY_W'(1);
          s0_d       = s1;
          wait_cnt_d = WAIT_LOAD;
          state_d    = S_WAIT;
        end
      end

      S_NEXT: begin
        if (!mode_q || (cur_addr_q == LAST_ADDR)) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cur_addr_d = cur_addr_q + 3'd1;
          state_d    = S_SAMPLE;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      valid_q    <= '0;
      blank_q    <= '0;
      err_q      <= 1'b0;
      mode_q     <= 1'b0;
      cur_addr_q <= '0;
      s0_q       <= '0;
      wait_cnt_q <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      cur_addr_q <= cur_addr_d;
      s0_q       <= s0_d;
      wait_cnt_q <= wait_cnt_d;
      retry_q    <= retry_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DIGITS = digits_q;
  assign VALID  = valid_q;
  assign BLANK  = blank_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Bench for seg7_readback: directed scenarios plus random readbacks checked
// against a table-driven model of the display decode and handshake latency.
module tb_seg7_readback;
  localparam int DWELL     = 4;
  localparam int MAX_RETRY = 3;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [6:0]  hex [6];
  logic        tog_en = 1'b0;
  logic [6:0]  tog_pat = 7'h3F;
  logic [6:0]  hex1_in;

  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [23:0] digits_a, digits_b;
  logic [5:0]  valid_a, blank_a, valid_b, blank_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_dig [6];
  logic       m_val [6];
  logic       m_blk [6];
  logic       m_err;

  assign hex1_in = tog_en ? tog_pat : hex[1];

  seg7_readback #(.DWELL(DWELL), .MAX_RETRY(MAX_RETRY), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .CLOCK(clk), .RESET(rst), .START(start_a), .MODE(mode), .ADDR(addr),
    .HEX0(hex[0]), .HEX1(hex1_in), .HEX2(hex[2]), .HEX3(hex[3]), .HEX4(hex[4]), .HEX5(hex[5]),
    .BUSY(busy_a), .DONE(done_a), .DIGITS(digits_a), .VALID(valid_a), .BLANK(blank_a), .ERR(err_a)
  );

  seg7_readback #(.DWELL(DWELL), .MAX_RETRY(MAX_RETRY), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .CLOCK(clk), .RESET(rst), .START(start_b), .MODE(mode), .ADDR(addr),
    .HEX0(hex[0]), .HEX1(hex1_in), .HEX2(hex[2]), .HEX3(hex[3]), .HEX4(hex[4]), .HEX5(hex[5]),
    .BUSY(busy_b), .DONE(done_b), .DIGITS(digits_b), .VALID(valid_b), .BLANK(blank_b), .ERR(err_b)
  );

  always #5 clk = ~clk;

  // Toggles every cycle, so any two samples an odd number of cycles apart disagree.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tog_pat = (tog_pat == 7'h3F) ? 7'h06 : 7'h3F;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_dec(input logic [6:0] p, output logic [3:0] n, output logic v, output logic b);
    n = 4'h0;
    v = 1'b0;
    b = (p == 7'h00);
    for (int k = 0; k < 16; k++) begin
      if (p == GLYPH[k]) begin
        n = k[3:0];
        v = 1'b1;
      end
    end
  endtask

  function automatic int exp_lat(input bit md, input logic [2:0] ad);
    if (md) return 6 * (DWELL + 3) + 1;
    if (ad <= 3'd5) return DWELL + 4;
    return 1;
  endfunction

  task automatic model_apply(input bit md, input logic [2:0] ad);
    if (md) begin
      m_err = 1'b0;
      for (int i = 0; i < 6; i++) ref_dec(hex[i], m_dig[i], m_val[i], m_blk[i]);
    end else if (ad <= 3'd5) begin
      m_err = 1'b0;
      ref_dec(hex[ad], m_dig[ad], m_val[ad], m_blk[ad]);
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [23:0] ed;
    logic [5:0]  ev, eb;
    for (int i = 0; i < 6; i++) begin
      ed[i*4 +: 4] = m_dig[i];
      ev[i] = m_val[i];
      eb[i] = m_blk[i];
    end
    chk({tag, "_digits"}, 32'(digits_a), 32'(ed));
    chk({tag, "_valid"},  32'(valid_a),  32'(ev));
    chk({tag, "_blank"},  32'(blank_a),  32'(eb));
    chk({tag, "_err"},    32'(err_a),    32'(m_err));
  endtask

  // START is seen at edge 0; cycle c is the interval ending at edge c.
  task automatic run_op(input bit inst, input bit md, input logic [2:0] ad, input int exp_cyc,
                        input bit scramble, input int glitch_cyc, input int glitch_idx,
                        input logic [6:0] glitch_val, input int restart_cyc, input string tag);
    int ndone = 0;
    int first = -1;
    bit busy_bad = 1'b0;
    int win = exp_cyc + DWELL + 8;
    logic bsy, dn;
    @(negedge clk);
    mode = md;
    addr = ad;
    if (inst) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (scramble) begin
      mode = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7));
    end
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      bsy = inst ? busy_b : busy_a;
      dn  = inst ? done_b : done_a;
      if (dn) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (bsy !== (c <= exp_cyc)) busy_bad = 1'b1;
      if (c == glitch_cyc) hex[glitch_idx] = glitch_val;
      if (c == restart_cyc) begin
        if (inst) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_done_cycle"}, 32'(first), 32'(exp_cyc));
    chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
  endtask

  function automatic logic [6:0] rand_pat();
    int r = $urandom_range(0, 99);
    if (r < 60) return GLYPH[$urandom_range(0, 15)];
    if (r < 75) return 7'h00;
    return 7'($urandom);
  endfunction

  initial begin
    int ndone;
    bit md;
    logic [2:0] ad;
    for (int i = 0; i < 6; i++) begin
      hex[i] = 7'h00;
      m_dig[i] = 4'h0;
      m_val[i] = 1'b0;
      m_blk[i] = 1'b0;
    end
    m_err = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    check_model("reset");

    // Single readback of HEX2.
    hex[2] = 7'h5B;
    run_op(1'b0, 1'b0, 3'd2, exp_lat(1'b0, 3'd2), 1'b0, -1, 0, 7'h00, -1, "single_hex2");
    model_apply(1'b0, 3'd2);
    check_model("single_hex2");
    chk("single_hex2_nib", 32'(digits_a[11:8]), 32'd2);

    // Full scan with a mix of glyphs, blank and an illegal pattern.
    hex[0] = 7'h3F; hex[1] = 7'h06; hex[2] = 7'h77;
    hex[3] = 7'h7C; hex[4] = 7'h00; hex[5] = 7'h12;
    run_op(1'b0, 1'b1, 3'd0, exp_lat(1'b1, 3'd0), 1'b0, -1, 0, 7'h00, -1, "scan");
    model_apply(1'b1, 3'd0);
    check_model("scan");
    chk("scan_digits_const", 32'(digits_a), 32'h00BA10);
    chk("scan_valid_const", 32'(valid_a), 32'b001111);
    chk("scan_blank_const", 32'(blank_a), 32'b010000);

    // HEX1 never settles: every retry mismatches.
    tog_en = 1'b1;
    run_op(1'b0, 1'b0, 3'd1, DWELL + 4 + (MAX_RETRY - 1) * (DWELL + 1), 1'b0, -1, 0, 7'h00, -1,
           "unstable");
    tog_en = 1'b0;
    m_dig[1] = 4'h0; m_val[1] = 1'b0; m_blk[1] = 1'b0; m_err = 1'b1;
    check_model("unstable");

    hex[1] = 7'h06;
    run_op(1'b0, 1'b0, 3'd1, exp_lat(1'b0, 3'd1), 1'b0, -1, 0, 7'h00, -1, "restable");
    model_apply(1'b0, 3'd1);
    check_model("restable");

    // Out-of-range address.
    run_op(1'b0, 1'b0, 3'd6, exp_lat(1'b0, 3'd6), 1'b0, -1, 0, 7'h00, -1, "bad_addr");
    model_apply(1'b0, 3'd6);
    check_model("bad_addr");

    // One change between the two samples, then steady: one retry, new value wins.
    hex[3] = 7'h66;
    run_op(1'b0, 1'b0, 3'd3, DWELL + 4 + (DWELL + 1), 1'b0, 3, 3, 7'h6D, -1, "glitch");
    model_apply(1'b0, 3'd3);
    check_model("glitch");

    // START during BUSY must not queue a second operation.
    hex[4] = 7'h79;
    run_op(1'b0, 1'b0, 3'd4, exp_lat(1'b0, 3'd4), 1'b0, -1, 0, 7'h00, 4, "start_busy");
    model_apply(1'b0, 3'd4);
    check_model("start_busy");

    // Active-low instance.
    hex[0] = 7'h40;
    run_op(1'b1, 1'b0, 3'd0, exp_lat(1'b0, 3'd0), 1'b0, -1, 0, 7'h00, -1, "alow_zero");
    chk("alow_zero_nib", 32'(digits_b[3:0]), 32'd0);
    chk("alow_zero_valid", 32'(valid_b[0]), 32'd1);
    chk("alow_zero_blank", 32'(blank_b[0]), 32'd0);
    hex[0] = 7'h7F;
    run_op(1'b1, 1'b0, 3'd0, exp_lat(1'b0, 3'd0), 1'b0, -1, 0, 7'h00, -1, "alow_blank");
    chk("alow_blank_blank", 32'(blank_b[0]), 32'd1);
    chk("alow_blank_valid", 32'(valid_b[0]), 32'd0);

    // Random readbacks; MODE/ADDR are scrambled after START to exercise latching.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 6; i++) hex[i] = rand_pat();
      md = 1'($urandom_range(0, 3) == 0);
      ad = 3'($urandom_range(0, 7));
      run_op(1'b0, md, ad, exp_lat(md, ad), 1'b1, -1, 0, 7'h00, -1, $sformatf("rand%0d", it));
      model_apply(md, ad);
      check_model($sformatf("rand%0d", it));
    end

    // Reset in the middle of a scan aborts with no DONE.
    ndone = 0;
    @(negedge clk);
    mode = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      m_dig[i] = 4'h0; m_val[i] = 1'b0; m_blk[i] = 1'b0;
    end
    m_err = 1'b0;
    chk("midreset_busy", 32'(busy_a), 32'd0);
    chk("midreset_done_now", 32'(done_a), 32'd0);
    check_model("midreset");
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("midreset_no_done", 32'(ndone), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
